// File: rtl/mips_mem_router_pkg.sv
// Shared definitions for the MIPS load/store memory-map router.
// Contents: memory-map limits, region index constants, router FSM state
// type and the default region base/last/read-only tables used as parameter
// defaults by mips_mem_router and mips_region_decode.
package mips_mem_router_pkg;

  localparam int N_MEM_REGIONS = 4;

  localparam int REG_IDX_TEXT  = 0;
  localparam int REG_IDX_DATA  = 1;
  localparam int REG_IDX_STACK = 2;
  localparam int REG_IDX_MMIO  = 3;

  // Memory-map limits (inclusive)
  localparam logic [31:0] TEXT_LOWER                = 32'h0040_0000;
  localparam logic [31:0] MEM_MAP_TEXT_UPPER_LIMIT  = 32'h0FFF_FFFF;
  localparam logic [31:0] DATA_LOWER                = 32'h1001_0000;
  localparam logic [31:0] MEM_MAP_DATA_UPPER_LIMIT  = 32'h1003_FFFF;
  localparam logic [31:0] MEM_MAP_STACK_LOWER_LIMIT = 32'h7FFF_0000;
  localparam logic [31:0] STACK_UPPER               = 32'h7FFF_FFFF;
  localparam logic [31:0] MMIO_LOWER                = 32'hFFFF_0000;
  localparam logic [31:0] MEM_MAP_MMIO_UPPER_LIMIT  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } t_router_state;

  // Region 0 occupies the least significant ADDR_W bits
  localparam logic [N_MEM_REGIONS*32-1:0] DEF_REGION_BASE =
    {MMIO_LOWER, MEM_MAP_STACK_LOWER_LIMIT, DATA_LOWER, TEXT_LOWER};
  localparam logic [N_MEM_REGIONS*32-1:0] DEF_REGION_LAST =
    {MEM_MAP_MMIO_UPPER_LIMIT, STACK_UPPER, MEM_MAP_DATA_UPPER_LIMIT, MEM_MAP_TEXT_UPPER_LIMIT};
  localparam logic [N_MEM_REGIONS-1:0] DEF_REGION_RO = 4'b0001;

endpackage

// File: rtl/mips_mem_router_if.sv
// Bus bundle between the core load/store port, the router and the region
// slaves.
//   master : core side plus slave models (drives req_*, slv_ack, slv_rdata)
//   slave  : router side (drives req_ready, rsp_*, slv_sel/we/addr/wdata/be)
interface mips_mem_router_if
  import mips_mem_router_pkg::*;
#(
  parameter int N_REGIONS = N_MEM_REGIONS,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [ADDR_W-1:0]           req_addr;
  logic [DATA_W-1:0]           req_wdata;
  logic [DATA_W/8-1:0]         req_be;
  logic                        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        rsp_err;
  logic [N_REGIONS-1:0]        slv_sel;
  logic                        slv_we;
  logic [ADDR_W-1:0]           slv_addr;
  logic [DATA_W-1:0]           slv_wdata;
  logic [DATA_W/8-1:0]         slv_be;
  logic [N_REGIONS-1:0]        slv_ack;
  logic [N_REGIONS*DATA_W-1:0] slv_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, slv_ack, slv_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  slv_sel, slv_we, slv_addr, slv_wdata, slv_be
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, slv_ack, slv_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output slv_sel, slv_we, slv_addr, slv_wdata, slv_be
  );
endinterface

// File: rtl/mips_mem_router_decode.sv
// mips_region_decode: combinational address decoder for the memory router.
// Ports:
//   addr, we  : request address and write flag
//   hit_oh    : one-hot matching region (lowest index wins on overlap)
//   idx       : index of the winning region
//   hit_any   : some region matched
//   ro_viol   : write to a read-only region
//   offset    : addr minus the winning region's base
module mips_region_decode
  import mips_mem_router_pkg::*;
#(
  parameter int                          N_REGIONS   = N_MEM_REGIONS,
  parameter int                          ADDR_W      = 32,
  parameter int                          IDX_W       = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LAST = DEF_REGION_LAST,
  parameter logic [N_REGIONS-1:0]        REGION_RO   = DEF_REGION_RO
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 we,
  output logic [N_REGIONS-1:0] hit_oh,
  output logic [IDX_W-1:0]     idx,
  output logic                 hit_any,
  output logic                 ro_viol,
  output logic [ADDR_W-1:0]    offset
);

  // Scan from the top index down so the lowest matching region is the last
  // assignment and therefore wins.
  always_comb begin
    hit_oh  = '0;
    idx     = '0;
    hit_any = 1'b0;
    ro_viol = 1'b0;
    offset  = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if ((addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
          (addr <= REGION_LAST[i*ADDR_W +: ADDR_W])) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        idx       = IDX_W'(i);
        hit_any   = 1'b1;
        ro_viol   = we & REGION_RO[i];
        offset    = addr - REGION_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/mips_mem_router.sv
// mips_mem_router: routes core load/store requests to N region slaves.
// Unmapped accesses and writes to read-only regions complete with an error
// response without selecting any slave.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : mips_mem_router_if.slave (core request/response and the
//                shared slave select/address/data/ack bus)
// Build option:
//   MEM_ROUTER_TIMEOUT_EN : adds a watchdog that ends an access with an
//                           error after TIMEOUT_CYC cycles without an ack.
module mips_mem_router
  import mips_mem_router_pkg::*;
#(
  parameter int                          N_REGIONS   = N_MEM_REGIONS,
  parameter int                          ADDR_W      = 32,
  parameter int                          DATA_W      = 32,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LAST = DEF_REGION_LAST,
  parameter logic [N_REGIONS-1:0]        REGION_RO   = DEF_REGION_RO
`ifdef MEM_ROUTER_TIMEOUT_EN
  ,
  parameter int                          TIMEOUT_CYC = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_mem_router_if.slave bus
);

  localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  t_router_state         state_q, state_d;
  logic [N_REGIONS-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   be_q, be_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [N_REGIONS-1:0]  dec_hit_oh;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_hit_any;
  logic                  dec_ro_viol;
  logic [ADDR_W-1:0]     dec_offset;
  logic                  ack_hit;
  logic [DATA_W-1:0]     rdata_sel;

  mips_region_decode #(
    .N_REGIONS  (N_REGIONS),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .REGION_BASE(REGION_BASE),
    .REGION_LAST(REGION_LAST),
    .REGION_RO  (REGION_RO)
  ) u_decode (
    .addr   (bus.req_addr),
    .we     (bus.req_we),
    .hit_oh (dec_hit_oh),
    .idx    (dec_idx),
    .hit_any(dec_hit_any),
    .ro_viol(dec_ro_viol),
    .offset (dec_offset)
  );

  // Only the selected region's ack counts; sel_q is zero outside ACCESS.
  assign ack_hit   = |(bus.slv_ack & sel_q);
  assign rdata_sel = bus.slv_rdata[idx_q*DATA_W +: DATA_W];

`ifdef MEM_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic             wdog_expire;

  assign wdog_inc    = wdog_q + 1'b1;
  assign wdog_expire = (wdog_inc == CNT_W'(TIMEOUT_CYC));
  // Outside ACCESS the count sits at zero, so every entry starts fresh.
  assign wdog_d      = ((state_q == ACCESS) && !ack_hit) ? wdog_inc : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (!dec_hit_any || dec_ro_viol) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
            sel_d   = dec_hit_oh;
            idx_d   = dec_idx;
            we_d    = bus.req_we;
            addr_d  = dec_offset;
            wdata_d = bus.req_wdata;
            be_d    = bus.req_be;
          end
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          state_d = RESP;
          sel_d   = '0;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : rdata_sel;
        end
`ifdef MEM_ROUTER_TIMEOUT_EN
        else if (wdog_expire) begin
          state_d = RESP;
          sel_d   = '0;
          err_d   = 1'b1;
          rdata_d = '0;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.slv_sel   = sel_q;
  assign bus.slv_we    = we_q;
  assign bus.slv_addr  = addr_q;
  assign bus.slv_wdata = wdata_q;
  assign bus.slv_be    = be_q;

endmodule

// File: tb/tb_mips_mem_router.sv
module tb_mips_mem_router;

  logic clk = 1'b0;
  logic rst_n;
  int   tests  = 0;
  int   failed = 0;

  mips_mem_router_if bus();

  mips_mem_router dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          dly;       // select cycles before the slave acks
    bit          noise;     // unselected regions ack while waiting
    logic [31:0] slv_data;
    logic [3:0]  exp_sel;
    logic [31:0] exp_off;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;   // cycles from acceptance edge to rsp_valid
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string n, logic we, logic [31:0] a, logic [31:0] wd,
                              logic [3:0] be, int dly, bit noise, logic [31:0] sd,
                              logic [3:0] es, logic [31:0] eo, logic [31:0] er,
                              logic ee, int lat);
    vec_t v;
    v.name = n; v.we = we; v.addr = a; v.wdata = wd; v.be = be; v.dly = dly;
    v.noise = noise; v.slv_data = sd; v.exp_sel = es; v.exp_off = eo;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int          cyc;
    int          sel_cyc;
    bit          got;
    bit          ready_hi;
    bit          hold_bad;
    logic [3:0]  sel_seen;
    logic [31:0] off_seen;
    logic [31:0] wd_seen;
    logic        we_seen;
    logic [3:0]  be_seen;
    check({v.name, " ready_before"}, bus.req_ready, 1);
    for (int i = 0; i < 4; i++)
      bus.slv_rdata[i*32 +: 32] = v.exp_sel[i] ? v.slv_data : (32'hA5A5_0000 | 32'(i));
    issue(v.we, v.addr, v.wdata, v.be);
    cyc = 1; sel_cyc = 0; got = 0; ready_hi = 0; hold_bad = 0;
    sel_seen = '0; off_seen = '0; wd_seen = '0; we_seen = 1'b0; be_seen = '0;
    while (!got && cyc <= 40) begin
      bus.slv_ack = '0;
      if (bus.rsp_valid) begin
        got = 1;
      end else begin
        if (bus.req_ready) ready_hi = 1;
        if (bus.slv_sel != '0) begin
          if (sel_cyc == 0) begin
            sel_seen = bus.slv_sel; off_seen = bus.slv_addr; wd_seen = bus.slv_wdata;
            we_seen = bus.slv_we; be_seen = bus.slv_be;
          end else if (bus.slv_sel !== sel_seen || bus.slv_addr !== off_seen ||
                       bus.slv_wdata !== wd_seen || bus.slv_we !== we_seen ||
                       bus.slv_be !== be_seen) begin
            hold_bad = 1;
          end
          if (sel_cyc == v.dly) bus.slv_ack = bus.slv_sel;
          else if (v.noise) bus.slv_ack = ~bus.slv_sel;
          sel_cyc++;
        end
        step();
        cyc++;
      end
    end
    check({v.name, " rsp_seen"}, 32'(got), 1);
    check({v.name, " latency"}, cyc, v.exp_lat);
    check({v.name, " rsp_err"}, bus.rsp_err, v.exp_err);
    check({v.name, " rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
    check({v.name, " slv_sel"}, sel_seen, v.exp_sel);
    check({v.name, " sel_at_rsp"}, bus.slv_sel, 0);
    check({v.name, " ready_busy"}, 32'(ready_hi), 0);
    check({v.name, " ready_in_rsp"}, bus.req_ready, 0);
    if (v.exp_sel != '0) begin
      check({v.name, " slv_addr"}, off_seen, v.exp_off);
      check({v.name, " slv_we"}, we_seen, v.we);
      check({v.name, " slv_wdata"}, wd_seen, v.wdata);
      check({v.name, " slv_be"}, be_seen, v.be);
      check({v.name, " held"}, 32'(hold_bad), 0);
    end
    step();
    check({v.name, " rsp_pulse"}, bus.rsp_valid, 0);
    check({v.name, " ready_after"}, bus.req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end, got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int  lat;
    bit  quiet;
    bit  got;

    vecs[0]  = mk("rd_data",       0, 32'h1001_0008, 32'h0,         4'hF, 0, 0, 32'hDEAD_BEEF, 4'b0010, 32'h8,       32'hDEAD_BEEF, 0, 2);
    vecs[1]  = mk("wr_text_ro",    1, 32'h0040_0004, 32'h1111_2222, 4'hF, 0, 0, 32'h0,         4'b0000, 32'h0,       32'h0,         1, 1);
    vecs[2]  = mk("rd_unmapped",   0, 32'h2000_0000, 32'h0,         4'hF, 0, 0, 32'h0,         4'b0000, 32'h0,       32'h0,         1, 1);
    vecs[3]  = mk("wr_mmio",       1, 32'hFFFF_0004, 32'h1234_5678, 4'h3, 5, 1, 32'h55AA_55AA, 4'b1000, 32'h4,       32'h0,         0, 7);
    vecs[4]  = mk("rd_text",       0, 32'h0040_0010, 32'h0,         4'hF, 1, 1, 32'h0000_1111, 4'b0001, 32'h10,      32'h0000_1111, 0, 3);
    vecs[5]  = mk("rd_stack",      0, 32'h7FFF_FFFC, 32'h0,         4'hF, 0, 0, 32'h1357_2468, 4'b0100, 32'hFFFC,    32'h1357_2468, 0, 2);
    vecs[6]  = mk("wr_data_base",  1, 32'h1001_0000, 32'hCAFE_BABE, 4'hC, 2, 1, 32'h7777_7777, 4'b0010, 32'h0,       32'h0,         0, 4);
    vecs[7]  = mk("rd_below_data", 0, 32'h1000_FFFF, 32'h0,         4'hF, 0, 0, 32'h0,         4'b0000, 32'h0,       32'h0,         1, 1);
    vecs[8]  = mk("rd_data_last",  0, 32'h1003_FFFF, 32'h0,         4'hF, 0, 0, 32'h89AB_CDEF, 4'b0010, 32'h2_FFFF,  32'h89AB_CDEF, 0, 2);
    vecs[9]  = mk("rd_above_data", 0, 32'h1004_0000, 32'h0,         4'hF, 0, 0, 32'h0,         4'b0000, 32'h0,       32'h0,         1, 1);
    vecs[10] = mk("rd_mmio_last",  0, 32'hFFFF_FFFF, 32'h0,         4'hF, 3, 0, 32'h7E57_DA7A, 4'b1000, 32'hFFFF,    32'h7E57_DA7A, 0, 5);
    vecs[11] = mk("wr_text_last",  1, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0,         4'b0000, 32'h0,       32'h0,         1, 1);
    vecs[12] = mk("rd_below_text", 0, 32'h003F_FFFF, 32'h0,         4'hF, 0, 0, 32'h0,         4'b0000, 32'h0,       32'h0,         1, 1);

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0; bus.slv_ack = '0; bus.slv_rdata = '0;
    #13;
    check("rst req_ready", bus.req_ready, 1);
    check("rst rsp_valid", bus.rsp_valid, 0);
    check("rst rsp_err",   bus.rsp_err, 0);
    check("rst rsp_rdata", bus.rsp_rdata, 0);
    check("rst slv_sel",   bus.slv_sel, 0);
    check("rst slv_we",    bus.slv_we, 0);
    check("rst slv_addr",  bus.slv_addr, 0);
    check("rst slv_wdata", bus.slv_wdata, 0);
    check("rst slv_be",    bus.slv_be, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Slave that never acks
    bus.slv_rdata = {4{32'hCAFE_F00D}};
    issue(0, 32'h1001_0008, 32'h0, 4'hF);
`ifdef MEM_ROUTER_TIMEOUT_EN
    lat = 1; got = 0;
    while (!got && lat <= 40) begin
      if (bus.rsp_valid) got = 1;
      else begin step(); lat++; end
    end
    check("wdog rsp_seen", 32'(got), 1);
    check("wdog latency", lat, 17);
    check("wdog rsp_err", bus.rsp_err, 1);
    check("wdog rsp_rdata", bus.rsp_rdata, 0);
    check("wdog sel_dropped", bus.slv_sel, 0);
    repeat (3) step();
    bus.slv_ack = 4'b0010;
    step();
    bus.slv_ack = '0;
    quiet = 1;
    repeat (4) begin
      if (bus.rsp_valid) quiet = 0;
      step();
    end
    check("wdog late_ack_ignored", 32'(quiet), 1);
`else
    quiet = 1;
    repeat (30) begin
      if (bus.rsp_valid || bus.slv_sel !== 4'b0010) quiet = 0;
      step();
    end
    check("noack waits", 32'(quiet), 1);
    bus.slv_ack = 4'b0010;
    step();
    bus.slv_ack = '0;
    check("noack rsp_valid", bus.rsp_valid, 1);
    check("noack rsp_err", bus.rsp_err, 0);
    check("noack rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    step();
`endif
    check("after_noack ready", bus.req_ready, 1);

    // Reset pulse in the middle of an access
    issue(0, 32'h1001_0008, 32'h0, 4'hF);
    step();
    check("rstmid sel_before", bus.slv_sel, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid sel_async", bus.slv_sel, 0);
    check("rstmid ready", bus.req_ready, 1);
    bus.slv_ack = 4'b0010;
    quiet = 1;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) quiet = 0;
    end
    bus.slv_ack = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      step();
      if (bus.rsp_valid || bus.slv_sel != '0) quiet = 0;
    end
    check("rstmid no_rsp", 32'(quiet), 1);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
